spike_rate_decoder: RTL and testbench
=====================================

// Module: spike_rate_decoder
// PURPOSE
//  Output-side counterpart of input_neuron: turns the spike trains of the output
//  neuron layer back into numbers. Counts spikes per neuron over a fixed window of
//  T_WINDOW enabled cycles, snapshots the counts, then scans them sequentially
//  for the winner (argmax). The result goes out over a valid/ready handshake to the
//  classifier/host logic.
// PARAMETERS
//  N_NEURONS  4    number of spike inputs (>= 2)
//  T_WINDOW   250  window length in en-qualified cycles (>= N_NEURONS+1)
//  CNT_W      8    per-neuron count width; counts saturate at 2**CNT_W-1
//  IDX_W      2    winner index width, = $clog2(N_NEURONS)
// PORTS
//  clk          in   1             clock
//  rst          in   1             synchronous, active-high reset
//  en           in   1             time-step enable (same strobe as the neuron layer)
//  spikes       in   N_NEURONS     out_spike of each output neuron, bit i = neuron i
//  res_ready    in   1             consumer accepts result
//  res_valid    out  1             result fields valid
//  winner_idx   out  IDX_W         index of max count (lowest index on tie)
//  winner_cnt   out  CNT_W         max count
//  tie          out  1             another neuron equals winner_cnt (incl. all-zero)
//  counts_flat  out  N*CNT_W       snapshot counts, neuron i at [i*CNT_W +: CNT_W]
//  overrun      out  1             sticky: window ended while result not consumed
// BEHAVIOUR
//  Reset: all outputs 0; tick=0; live counters=0; state ACC.
//  Window: tick counts 0..T_WINDOW-1 on en, then wraps. en=0 freezes tick and live
//   counters, and spikes are ignored. The FSM keeps running whatever en is.
//  Counting: on en, cnt[i] += spikes[i], saturating at max. No wrap.
//  Window end (en && tick==T_WINDOW-1): this cycle's spikes are included. Live
//   counters clear to 0 at the same edge. Spikes in the next cycle count in the
//   new window.
//   - state==ACC: snapshot = cnt+spike (saturated) -> counts_flat.
//     best=snap[0], idx=0, tie=0; go to SCAN with ptr=1.
//   - state!=ACC: the snapshot is dropped, overrun<=1, and the pending result is kept.
//  FSM:
//   ACC  -> SCAN on window end.
//   SCAN: one compare per cycle at ptr.
//     snap[ptr] > best : best=snap[ptr], idx=ptr, tie=0.
//     snap[ptr] == best: tie=1.
//     ptr==N-1 -> HOLD, res_valid<=1.
//   HOLD -> ACC when res_valid && res_ready, res_valid<=0.
//  Latency: res_valid is high after edge E+(N_NEURONS-1), where E is the window-end edge.
//  Handshake: result fields stay stable while res_valid=1. No combinational ready->valid
//   path. res_ready is ignored when res_valid=0.
//  counts_flat holds the last snapshot until the next accepted snapshot.
//  rst mid-SCAN/HOLD aborts: res_valid=0, overrun=0, partial window discarded.
// STRUCTURE
//  snn_pkg: state enum {ACC,SCAN,HOLD}, sat_inc function, default CNT_W/T_WINDOW.
//  Sub-module spike_counter (one per neuron, generate loop):
//   ports clk, rst, en, spike, clr, cnt. clr has priority over increment, and the
//   snapshot value cnt+spike is available combinationally.
//  Top: tick counter, snapshot regs, argmax FSM, output regs.
// TESTING (bench: N_NEURONS=4, T_WINDOW=10, CNT_W=8, en=1 unless stated)
//  1 rst held 3 cycles mid-window -> all outputs 0.
//    After release, first valid appears only after a full 10 en-cycles.
//  2 Neuron 2 spikes every cycle, others never -> counts {0,0,10,0}, winner_idx=2,
//    winner_cnt=10, tie=0; res_valid 3 cycles after the window-end edge.
//  3 Neurons 1 and 3 each 5 spikes, others 2 -> winner_idx=1, winner_cnt=5, tie=1.
//    No spikes at all -> idx=0, cnt=0, tie=1.
//  4 en toggled 1/0 alternately -> window spans 20 clocks.
//    Spikes while en=0 are not counted (pulse only on en=0 cycles -> count 0).
//  5 res_ready held 0 across the next window end -> overrun=1, old result stable.
//    Then ready=1 -> accepted, state ACC; next window reports normally.
//  6 T_WINDOW=300, CNT_W=8, constant spike -> count saturates at 255, no wrap.
//    Window-end spike is counted: spike only at tick 9 -> count 1.

Source files
------------

// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and helpers for the spike-rate decoder: FSM states, default
// sizing and the saturating increment used by the per-neuron counters.
package spike_rate_decoder_pkg;

  typedef enum logic [1:0] {
    ACC,
    SCAN,
    HOLD
  } state_e;

  localparam int unsigned DEF_N_NEURONS = 4;
  localparam int unsigned DEF_T_WINDOW  = 250;
  localparam int unsigned DEF_CNT_W     = 8;

  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic        inc,
                                          input logic [31:0] maxv);
    if (inc && (v < maxv)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_counter.sv
// Per-neuron spike counter: saturating count on en, clr wins over increment.
module spike_counter
  import spike_rate_decoder_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), spike, CNT_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spikes per neuron over a window of en cycles,
// snapshots the counts and scans them sequentially for the argmax winner.
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter int unsigned N_NEURONS = DEF_N_NEURONS,
  parameter int unsigned T_WINDOW  = DEF_T_WINDOW,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_NEURONS-1:0]       spikes,
  input  logic                       res_ready,
  output logic                       res_valid,
  output logic [IDX_W-1:0]           winner_idx,
  output logic [CNT_W-1:0]           winner_cnt,
  output logic                       tie,
  output logic [N_NEURONS*CNT_W-1:0] counts_flat,
  output logic                       overrun
);

  localparam int unsigned      TICK_W    = $clog2(T_WINDOW);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(T_WINDOW - 1);
  localparam logic [IDX_W-1:0]  PTR_LAST  = IDX_W'(N_NEURONS - 1);
  localparam logic [31:0]       CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              win_end;

  logic [N_NEURONS-1:0][CNT_W-1:0] live_cnt;
  logic [N_NEURONS-1:0][CNT_W-1:0] live_snap;
  logic [N_NEURONS-1:0][CNT_W-1:0] snap_q, snap_d;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             tie_q, tie_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  assign win_end = en && (tick_q == TICK_LAST);

  always_comb begin
    tick_d = tick_q;
    if (en) tick_d = win_end ? '0 : tick_q + TICK_W'(1);
  end

  // Live counters clear on the window-end edge; the snapshot folds that
  // cycle's spike in combinationally so it is not lost.
  for (genvar g = 0; g < N_NEURONS; g++) begin : g_cnt
    spike_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .spike(spikes[g]),
      .clr  (win_end),
      .cnt  (live_cnt[g])
    );
    assign live_snap[g] = CNT_W'(sat_inc(32'(live_cnt[g]), spikes[g], CNT_MAX));
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    best_d  = best_q;
    tie_d   = tie_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      ACC: begin
        if (win_end) begin
          snap_d  = live_snap;
          best_d  = live_snap[0];
          idx_d   = '0;
          tie_d   = 1'b0;
          ptr_d   = IDX_W'(1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (snap_q[ptr_q] > best_q) begin
          best_d = snap_q[ptr_q];
          idx_d  = ptr_q;
          tie_d  = 1'b0;
        end else if (snap_q[ptr_q] == best_q) begin
          tie_d = 1'b1;
        end
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (valid_q && res_ready) begin
          state_d = ACC;
          valid_d = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
    if (win_end && (state_q != ACC)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      tick_q  <= '0;
      snap_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      best_q  <= '0;
      tie_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      snap_q  <= snap_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      tie_q   <= tie_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign res_valid   = valid_q;
  assign winner_idx  = idx_q;
  assign winner_cnt  = best_q;
  assign tie         = tie_q;
  assign counts_flat = snap_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: a window-level reference model pushes
// expected results; a monitor pops and compares when res_valid rises.
module tb_spike_rate_decoder;

  localparam int N = 4;
  localparam int T = 10;
  localparam int W = 8;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, res_ready;
  logic [N-1:0] spikes;
  logic         res_valid, tie, overrun;
  logic [1:0]   winner_idx;
  logic [W-1:0] winner_cnt;
  logic [N*W-1:0] counts_flat;

  logic         rst2, en2, ready2;
  logic [N-1:0] spikes2;
  logic         valid2, tie2, overrun2;
  logic [1:0]   idx2;
  logic [W-1:0] cnt2;
  logic [N*W-1:0] flat2;

  spike_rate_decoder #(
    .N_NEURONS(N), .T_WINDOW(T), .CNT_W(W), .IDX_W(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .spikes(spikes), .res_ready(res_ready),
    .res_valid(res_valid), .winner_idx(winner_idx), .winner_cnt(winner_cnt),
    .tie(tie), .counts_flat(counts_flat), .overrun(overrun)
  );

  spike_rate_decoder #(
    .N_NEURONS(N), .T_WINDOW(300), .CNT_W(W), .IDX_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst2), .en(en2), .spikes(spikes2), .res_ready(ready2),
    .res_valid(valid2), .winner_idx(idx2), .winner_cnt(cnt2),
    .tie(tie2), .counts_flat(flat2), .overrun(overrun2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  bit done2   = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [N*W-1:0] flat;
    int             idx;
    int             wcnt;
    bit             tie;
    int             vedge;
  } exp_t;

  exp_t q[$];

  // Reference model state: window position, per-neuron totals, pending result.
  int tick_m;
  int acc_m[N];
  bit pend_m;
  int acc_earliest;
  bit ovr_m;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_result(input int e);
    exp_t r;
    int   mx, cnt_mx;
    mx = -1;
    r.idx = 0;
    cnt_mx = 0;
    r.flat = '0;
    for (int i = 0; i < N; i++) begin
      r.flat[i*W +: W] = W'(acc_m[i]);
      if (acc_m[i] > mx) begin
        mx = acc_m[i];
        r.idx = i;
      end
    end
    for (int i = 0; i < N; i++) if (acc_m[i] == mx) cnt_mx++;
    r.wcnt  = mx;
    r.tie   = (cnt_mx > 1);
    r.vedge = e + 3;
    q.push_back(r);
  endtask

  task automatic step(input bit r, input bit e_, input logic [N-1:0] sp, input bit rdy);
    int e;
    bit wend, accept;
    rst = r; en = e_; spikes = sp; res_ready = rdy;
    e = edge_n + 1;
    if (r) begin
      tick_m = 0;
      for (int i = 0; i < N; i++) acc_m[i] = 0;
      pend_m = 0;
      ovr_m  = 0;
      q.delete();
    end else begin
      accept = pend_m && (e >= acc_earliest) && rdy;
      wend = 0;
      if (e_) begin
        for (int i = 0; i < N; i++) if (sp[i] && acc_m[i] < MAXC) acc_m[i]++;
        if (tick_m == T - 1) begin
          wend = 1;
          tick_m = 0;
        end else begin
          tick_m++;
        end
      end
      if (wend) begin
        if (!pend_m) begin
          push_result(e);
          pend_m = 1;
          acc_earliest = e + 4;
        end else begin
          ovr_m = 1;
        end
        for (int i = 0; i < N; i++) acc_m[i] = 0;
      end
      if (accept) pend_m = 0;
    end
    @(posedge clk);
    #1;
    check("overrun", overrun, ovr_m);
    if (r) begin
      check("rst_valid", res_valid, 0);
      check("rst_fields", {counts_flat, winner_idx, winner_cnt, tie}, 0);
    end
  endtask

  // Monitor: a rising res_valid presents a new result; later cycles must hold it.
  initial begin : monitor
    bit prev_v;
    exp_t cur;
    logic [N*W+2+W:0] held;
    prev_v = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 0;
      end else if (res_valid) begin
        if (!prev_v) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid=1 expected no pending result (t=%0t)", $time);
          end else begin
            cur = q.pop_front();
            check("counts_flat", counts_flat, cur.flat);
            check("winner_idx", winner_idx, cur.idx);
            check("winner_cnt", winner_cnt, cur.wcnt);
            check("tie", tie, cur.tie);
            check("latency_edge", edge_n, cur.vedge);
          end
          held = {counts_flat, winner_idx, winner_cnt, tie};
        end else begin
          check("stable", {counts_flat, winner_idx, winner_cnt, tie}, held);
        end
        prev_v = 1;
      end else begin
        prev_v = 0;
      end
    end
  end

  // Long-window instance: saturation at 255 with no wrap.
  initial begin : sat_check
    int k;
    rst2 = 1; en2 = 1; spikes2 = '0; ready2 = 1;
    repeat (2) @(posedge clk);
    #1 rst2 = 0;
    k = 0;
    while (k < 400 && !valid2) begin
      spikes2 = {1'b0, (k % 2 == 0), 1'b0, 1'b1};
      @(posedge clk);
      #1;
      k++;
    end
    check("sat_valid", valid2, 1);
    check("sat_latency", k, 303);
    check("sat_counts", flat2, {8'd0, 8'd150, 8'd0, 8'd255});
    check("sat_idx", idx2, 0);
    check("sat_cnt", cnt2, 255);
    check("sat_tie", tie2, 0);
    done2 = 1;
  end

  initial begin : driver
    int nn[N];
    logic [N-1:0] sp;
    int guard;

    // Reset, partial window, then a mid-window reset.
    repeat (3) step(1, 0, '0, 1);
    repeat (4) step(0, 1, N'($urandom), 1);
    repeat (3) step(1, 1, '1, 1);

    // Neuron 2 fires every cycle.
    repeat (T) step(0, 1, 4'b0100, 1);

    // Neurons 1 and 3 fire 5 times, others twice.
    nn = '{2, 5, 2, 5};
    for (int t = 0; t < T; t++) begin
      for (int i = 0; i < N; i++) sp[i] = (t < nn[i]);
      step(0, 1, sp, 1);
    end

    // Silent window.
    repeat (T) step(0, 1, '0, 1);

    // en alternating; spikes only on en=0 cycles.
    for (int k = 0; k < 2 * T; k++) begin
      if (k % 2 == 0) step(0, 1, '0, 1);
      else            step(0, 0, '1, 1);
    end

    // Consumer stalls across a window end.
    repeat (T) step(0, 1, N'($urandom), 0);
    repeat (T) step(0, 1, N'($urandom), 0);
    repeat (5) step(0, 1, N'($urandom), 0);
    check("stall_overrun", overrun, 1);
    check("stall_valid", res_valid, 1);
    repeat (5) step(0, 1, N'($urandom), 1);
    check("stall_accepted", res_valid, 0);
    repeat (T) step(0, 1, N'($urandom), 1);

    // Reset clears overrun; then a spike only on the window-end tick.
    repeat (2) step(1, 0, '0, 1);
    for (int t = 0; t < T; t++) step(0, 1, (t == T - 1) ? 4'b1000 : 4'b0000, 1);
    repeat (T) step(0, 1, N'($urandom), 1);
    step(0, 1, N'($urandom), 1);
    repeat (3) step(1, 0, '0, 1);

    // Randomised traffic with random en and back-pressure, one reset inside.
    for (int k = 0; k < 300; k++) begin
      if (k >= 150 && k < 152) begin
        step(1, 0, '0, 1);
      end else begin
        for (int i = 0; i < N; i++) sp[i] = ($urandom_range(0, 3) <= i % 3);
        step(0, ($urandom_range(0, 3) != 0), sp, 1'($urandom_range(0, 1)));
      end
    end

    repeat (20) step(0, 0, '0, 1);
    check("queue_drained", q.size(), 0);

    guard = 0;
    while (!done2 && guard < 1000) begin
      step(0, 0, '0, 1);
      guard++;
    end
    check("sat_done", done2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
